brlshift_pipe: RTL

//  Parametrised, pipelined barrel shifter for the GPU/DSP ALU: logical, arithmetic and rotate shifts

---
 rtl/brl_pkg.sv | 46 ++++
 rtl/brl_level.sv | 19 +
 rtl/brlshift_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/brl_pkg.sv
// Shared types and count decode for the pipelined barrel shifter.
package brl_pkg;

    typedef enum logic [1:0] {
        LSH = 2'b00,
        ASH = 2'b01,
        ROR = 2'b10,
        ROL = 2'b11
    } brl_mode_t;

    localparam int MAX_LOGW = 6;

    // right=0 means the operand is bit-reversed around the right-shift levels.
    // fill marks an arithmetic right shift (fill with the operand MSB).
    typedef struct packed {
        logic                right;
        logic                fill;
        logic [MAX_LOGW-1:0] amount;
        logic                outflow;
    } brl_dec_t;

    function automatic brl_dec_t decode_cnt(input brl_mode_t mode,
                                            input logic [63:0] cnt,
                                            input int unsigned logw);
        brl_dec_t    d;
        logic [63:0] mag;
        logic [63:0] lim;
        logic [63:0] mask;
        lim  = 64'd1 << logw;
        mask = lim - 64'd1;
        d    = '0;
        if (mode == ROR || mode == ROL) begin
            d.right  = (mode == ROR);
            d.amount = cnt[MAX_LOGW-1:0] & mask[MAX_LOGW-1:0];
        end else begin
            // the most negative count negates to itself, which still compares >= lim
            mag       = cnt[63] ? -cnt : cnt;
            d.right   = !cnt[63];
            d.fill    = (mode == ASH) && !cnt[63];
            d.outflow = (mag >= lim);
            d.amount  = mag[MAX_LOGW-1:0] & mask[MAX_LOGW-1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/brl_level.sv
// One mux level of the right-shift/rotate network: conditionally shifts right by SHIFT.
module brl_level #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             fill_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shifted;

    assign shifted = rot_i ? {d_i[SHIFT-1:0], d_i[WIDTH-1:SHIFT]}
                           : {{SHIFT{fill_i}}, d_i[WIDTH-1:SHIFT]};
    assign q_o     = en_i ? shifted : d_i;

endmodule

// File: rtl/brlshift_pipe.sv
// Pipelined barrel shifter (LSH/ASH/ROR/ROL) with valid/ready flow control and flush.
module brlshift_pipe
    import brl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CNTW   = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [CNTW-1:0]  cnt,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             zero
);

    localparam int LOGW  = $clog2(WIDTH);
    localparam int SPLIT = (LOGW + 1) / 2;
    localparam int NA    = LOGW - SPLIT;

    generate
        if (WIDTH < 8 || WIDTH > 64 || (1 << LOGW) != WIDTH) begin : g_bad_width
            $error("brlshift_pipe: WIDTH must be a power of two in 8..64");
        end
        if (CNTW < LOGW + 2 || CNTW > 64) begin : g_bad_cntw
            $error("brlshift_pipe: CNTW out of range");
        end
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("brlshift_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        for (int i = 0; i < WIDTH; i++) bitrev[i] = x[WIDTH-1-i];
    endfunction

    // ---------------- stage 0: count decode ----------------
    logic [63:0]      cnt_sx;
    brl_dec_t         dec;
    logic             fill0, rev0, rot0, carry0;
    logic [LOGW-1:0]  amt0;
    logic [WIDTH-1:0] data0;

    assign cnt_sx = 64'($signed(cnt));

    always_comb begin
        dec    = decode_cnt(brl_mode_t'(mode), cnt_sx, LOGW);
        rot0   = mode[1];
        rev0   = !dec.right;
        fill0  = dec.fill & din[WIDTH-1];
        carry0 = (rev0 && cnt != '0) ? din[WIDTH-1] : din[0];
        // outflow results are produced directly; the levels then pass them through
        if (dec.outflow) begin
            data0 = {WIDTH{fill0}};
            amt0  = '0;
            rev0  = 1'b0;
        end else begin
            data0 = rev0 ? bitrev(din) : din;
            amt0  = dec.amount[LOGW-1:0];
        end
    end

    // ---------------- flow control ----------------
    logic vo_q, va_q;
    logic ld_o, ld_a;

    assign ld_o     = !vo_q | out_ready;
    assign ld_a     = !va_q | ld_o;
    assign in_ready = ((STAGES == 2) ? ld_a : ld_o) | flush;

    // ---------------- optional mid-pipe register ----------------
    logic [LOGW:0][WIDTH-1:0] lvl;
    logic [WIDTH-1:0]         data_a_q;
    logic [NA-1:0]            amt_a_q;
    logic                     fill_a_q, rot_a_q, rev_a_q, carry_a_q;
    logic                     o_vin, rev_f, carry_f;

    assign lvl[0] = data0;

    generate
        if (STAGES == 2) begin : g_split
            always_ff @(posedge clk or negedge resetl) begin
                if (!resetl) begin
                    va_q      <= 1'b0;
                    data_a_q  <= '0;
                    amt_a_q   <= '0;
                    fill_a_q  <= 1'b0;
                    rot_a_q   <= 1'b0;
                    rev_a_q   <= 1'b0;
                    carry_a_q <= 1'b0;
                end else begin
                    if (flush)     va_q <= 1'b0;
                    else if (ld_a) va_q <= in_valid;
                    if (ld_a && in_valid) begin
                        data_a_q  <= lvl[SPLIT];
                        amt_a_q   <= amt0[LOGW-1:SPLIT];
                        fill_a_q  <= fill0;
                        rot_a_q   <= rot0;
                        rev_a_q   <= rev0;
                        carry_a_q <= carry0;
                    end
                end
            end
            assign o_vin   = va_q;
            assign rev_f   = rev_a_q;
            assign carry_f = carry_a_q;
        end else begin : g_flat
            assign va_q      = 1'b0;
            assign data_a_q  = '0;
            assign amt_a_q   = '0;
            assign fill_a_q  = 1'b0;
            assign rot_a_q   = 1'b0;
            assign rev_a_q   = 1'b0;
            assign carry_a_q = 1'b0;
            assign o_vin     = in_valid;
            assign rev_f     = rev0;
            assign carry_f   = carry0;
        end
    endgenerate

    // ---------------- mux levels ----------------
    for (genvar i = 0; i < LOGW; i++) begin : g_lvl
        logic [WIDTH-1:0] lin;
        logic             en, f, r;
        if (STAGES == 2 && i >= SPLIT) begin : g_late
            assign lin = (i == SPLIT) ? data_a_q : lvl[i];
            assign en  = amt_a_q[i-SPLIT];
            assign f   = fill_a_q;
            assign r   = rot_a_q;
        end else begin : g_early
            assign lin = lvl[i];
            assign en  = amt0[i];
            assign f   = fill0;
            assign r   = rot0;
        end
        brl_level #(.WIDTH(WIDTH), .SHIFT(1 << i)) u_lvl (
            .d_i   (lin),
            .en_i  (en),
            .fill_i(f),
            .rot_i (r),
            .q_o   (lvl[i+1])
        );
    end

    // ---------------- output stage ----------------
    logic [WIDTH-1:0] res_d, dout_q;
    logic             carry_q, zero_q;

    assign res_d = rev_f ? bitrev(lvl[LOGW]) : lvl[LOGW];

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            vo_q    <= 1'b0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            if (flush)     vo_q <= 1'b0;
            else if (ld_o) vo_q <= o_vin;
            if (ld_o && o_vin) begin
                dout_q  <= res_d;
                carry_q <= carry_f;
                zero_q  <= (res_d == '0);
            end
        end
    end

    assign out_valid = vo_q;
    assign dout      = dout_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule
